// File: rtl/addsub_result_decoder.sv
// addsub_result_decoder: turns an adder/subtracter result word {cout, s} plus
// the mode bit into sign, binary magnitude and packed BCD digits. The BCD
// conversion is iterative (shift-add-3), one magnitude bit per clock.
//
// Optional feature macro: ADDSUB_DEC_SEG_EN adds out_seg, active-low 7-segment
// codes (gfedcba per digit, most significant digit in the top bits).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready is high only while idle
//   in_sub, in_cout, in_s result word and the mode it was produced with
//   out_valid / out_ready output handshake; out_valid is high only when done
//   out_neg, out_mag      sign and unsigned magnitude (WIDTH+1 bits)
//   out_bcd               packed BCD of out_mag, most significant digit on top
//   out_seg               (ADDSUB_DEC_SEG_EN only) 7-segment codes of out_bcd
module addsub_result_decoder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic                  in_cout,
  input  logic [WIDTH-1:0]      in_s,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_neg,
  output logic [WIDTH:0]        out_mag,
  output logic [4*DIGITS-1:0]   out_bcd
`ifdef ADDSUB_DEC_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   out_seg
`endif
);

  localparam int unsigned MAG_W = WIDTH + 1;
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + MAG_W;
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [MAG_W-1:0]   mag_sh_q;
  logic               neg_q;
  logic [MAG_W-1:0]   mag_q;

  logic [WIDTH-1:0]   s_twos;
  logic               dec_neg;
  logic [MAG_W-1:0]   dec_mag;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_fin;
  logic               conv_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (conv_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign conv_last = (cnt_q == CNT_W'(1));

  // Decode sign/magnitude; a zero difference is never reported as negative
  always_comb begin
    s_twos  = ~in_s + WIDTH'(1);
    dec_neg = 1'b0;
    dec_mag = {1'b0, in_s};
    if (!in_sub) begin
      dec_mag = {in_cout, in_s};
    end else if (in_cout) begin
      dec_neg = (in_s != '0);
      dec_mag = {1'b0, s_twos};
    end
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in next mag bit
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sr_shift = {bcd_adj, mag_sh_q} << 1;
    bcd_fin  = sr_shift[SR_W-1:MAG_W];
  end

`ifdef ADDSUB_DEC_SEG_EN
  logic [7*DIGITS-1:0] seg_nxt;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Segment codes of the final BCD value
  always_comb begin
    seg_nxt = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      seg_nxt[7*i +: 7] = seg_of(bcd_fin[4*i +: 4]);
    end
  end
`endif

  // Handshake flags, conversion datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      mag_sh_q  <= '0;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      out_neg   <= 1'b0;
      out_mag   <= '0;
      out_bcd   <= '0;
`ifdef ADDSUB_DEC_SEG_EN
      out_seg   <= '1;
`endif
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q    <= CNT_LOAD;
            neg_q    <= dec_neg;
            mag_q    <= dec_mag;
            mag_sh_q <= dec_mag;
            bcd_q    <= '0;
          end
        end
        CONV: begin
          cnt_q    <= cnt_q - CNT_W'(1);
          bcd_q    <= bcd_fin;
          mag_sh_q <= sr_shift[MAG_W-1:0];
          if (conv_last) begin
            out_neg <= neg_q;
            out_mag <= mag_q;
            out_bcd <= bcd_fin;
`ifdef ADDSUB_DEC_SEG_EN
            out_seg <= seg_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_result_decoder.sv
// Bench for addsub_result_decoder: directed cases with literal expectations,
// then randomized words, all compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_addsub_result_decoder;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned MW = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sub = 1'b0, in_cout = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_s = '0;
  logic in_ready, out_valid, out_neg;
  logic [W:0] out_mag;
  logic [4*D-1:0] out_bcd;
`ifdef ADDSUB_DEC_SEG_EN
  logic [7*D-1:0] out_seg;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addsub_result_decoder #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_cout(in_cout), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neg(out_neg), .out_mag(out_mag), .out_bcd(out_bcd)
`ifdef ADDSUB_DEC_SEG_EN
    , .out_seg(out_seg)
`endif
  );

  // ---------------- reference model ----------------
  localparam logic [6:0] SEG_TAB [0:9] =
    '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int ref_mag(input logic sub, input logic cout, input logic [W-1:0] s);
    int v;
    if (!sub)      v = int'(cout) * (2 ** W) + int'(s);
    else if (!cout) v = int'(s);
    else           v = ((2 ** W) - int'(s)) % (2 ** W);
    return v;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] b;
    int r;
    b = '0;
    r = v;
    for (int i = 0; i < int'(D); i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [7*D-1:0] to_seg(input logic [4*D-1:0] b);
    logic [7*D-1:0] s;
    int d;
    for (int i = 0; i < int'(D); i++) begin
      d = int'(b[4*i +: 4]);
      s[7*i +: 7] = (d > 9) ? 7'h7F : SEG_TAB[d];
    end
    return s;
  endfunction

  logic m_ready, m_valid, m_neg, m_busy, p_neg;
  logic [MW-1:0] m_mag;
  logic [4*D-1:0] m_bcd;
  logic [7*D-1:0] m_seg;
  int p_mag = 0;
  int m_left = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int cyc = 0;

  // Timeline model: accept, then result WIDTH+1 edges later, then wait for out_ready
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0;
      m_neg <= 1'b0; m_mag <= '0; m_bcd <= '0; m_seg <= '1;
    end else begin
      cyc <= cyc + 1;
      if (m_ready && in_valid) begin
        m_ready <= 1'b0;
        m_busy  <= 1'b1;
        m_left  <= int'(W) + 1;
        p_mag   <= ref_mag(in_sub, in_cout, in_s);
        p_neg   <= in_sub && in_cout && (ref_mag(in_sub, in_cout, in_s) != 0);
        acc_cnt <= acc_cnt + 1;
        acc_cyc <= cyc + 1;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_neg   <= p_neg;
          m_mag   <= MW'(p_mag);
          m_bcd   <= to_bcd(p_mag);
          m_seg   <= to_seg(to_bcd(p_mag));
        end
        m_left <= m_left - 1;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_neg",   32'(out_neg),   32'(m_neg));
    chk("out_mag",   32'(out_mag),   32'(m_mag));
    chk("out_bcd",   32'(out_bcd),   32'(m_bcd));
`ifdef ADDSUB_DEC_SEG_EN
    chk("out_seg",   32'(out_seg),   32'(m_seg));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic sub, input logic cout, input logic [W-1:0] s);
    int base;
    int n;
    base = acc_cnt;
    n = 0;
    in_valid = 1'b1; in_sub = sub; in_cout = cout; in_s = s;
    while (acc_cnt == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt == base) chk("accept_timeout", 32'(acc_cnt), 32'(base + 1));
    #1;
    in_valid = 1'b0;
    in_s = W'($urandom);
    in_sub = 1'($urandom);
    in_cout = 1'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    #1;
  endtask

  task automatic take(input int stall);
    wait_valid();
    repeat (stall) @(negedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Literal expectations on the DUT, and the same literals pinning the model
  task automatic lit(input string t, input logic neg, input int mag, input logic [11:0] bcd);
    chk({t, "_neg"},       32'(out_neg), 32'(neg));
    chk({t, "_mag"},       32'(out_mag), 32'(mag));
    chk({t, "_bcd"},       32'(out_bcd), 32'(bcd));
    chk({t, "_model_mag"}, 32'(m_mag),   32'(mag));
    chk({t, "_model_bcd"}, 32'(m_bcd),   32'(bcd));
  endtask

  task automatic chk_latency(input string t);
    chk({t, "_latency"}, 32'(cyc - acc_cyc), 32'(W + 1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic sub, cout;
    logic [W-1:0] s;
    int base;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_mag",   32'(out_mag),   32'd0);
    chk("rst_out_bcd",   32'(out_bcd),   32'd0);
`ifdef ADDSUB_DEC_SEG_EN
    chk("rst_out_seg",   32'(out_seg),   32'h1FFFFF);
`endif
    #1 rst = 1'b0;

    // Add overflow 0x1FE with the consumer always ready
    out_ready = 1'b1;
    send(1'b0, 1'b1, 8'hFE);
    wait_valid();
    chk_latency("ovf");
    lit("ovf", 1'b0, 510, 12'h510);
    @(negedge clk);
    #1 out_ready = 1'b0;

    // 5 - 9
    send(1'b1, 1'b1, 8'hFC);
    wait_valid();
    lit("neg4", 1'b1, 4, 12'h004);
`ifdef ADDSUB_DEC_SEG_EN
    chk("neg4_seg", 32'(out_seg), 32'({7'h40, 7'h40, 7'h19}));
`endif
    take(0);

    // 0 - 255
    send(1'b1, 1'b1, 8'h01);
    wait_valid();
    lit("neg255", 1'b1, 255, 12'h255);
    take(1);

    // 7 - 7
    send(1'b1, 1'b0, 8'h00);
    wait_valid();
    lit("zero", 1'b0, 0, 12'h000);
    take(0);

    // Borrow-flagged zero must not be negative
    send(1'b1, 1'b1, 8'h00);
    wait_valid();
    lit("zero_b", 1'b0, 0, 12'h000);
    take(0);

    // Backpressure with a second word held on the input
    send(1'b0, 1'b0, 8'h12);
    wait_valid();
    in_valid = 1'b1; in_sub = 1'b1; in_cout = 1'b0; in_s = 8'h2A;
    base = acc_cnt;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_mag",       32'(out_mag),   32'd18);
      chk("bp_bcd",       32'(out_bcd),   32'h018);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_not_yet",    32'(acc_cnt),  32'(base));
    chk("bp_held_mag",   32'(out_mag),  32'd18);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_accepted",   32'(acc_cnt),  32'(base + 1));
    chk("bp_busy",       32'(in_ready), 32'd0);
    #1 in_valid = 1'b0;
    wait_valid();
    chk_latency("bp2");
    lit("bp2", 1'b0, 42, 12'h042);
    take(0);

    // Reset in the middle of a conversion
    send(1'b1, 1'b1, 8'h80);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_neg",       32'(out_neg),   32'd0);
    chk("mid_rst_mag",       32'(out_mag),   32'd0);
    chk("mid_rst_bcd",       32'(out_bcd),   32'd0);
`ifdef ADDSUB_DEC_SEG_EN
    chk("mid_rst_seg",       32'(out_seg),   32'h1FFFFF);
`endif
    @(negedge clk);
    #1 rst = 1'b0;
    send(1'b1, 1'b1, 8'h9C);
    wait_valid();
    chk_latency("post_rst");
    lit("post_rst", 1'b1, 100, 12'h100);
    take(0);

    // Randomized words with random gaps, early out_ready and stalls
    for (int k = 0; k < 60; k++) begin
      sub  = 1'($urandom);
      cout = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       s = 8'h00;
        1:       s = 8'h01;
        2:       s = 8'hFF;
        default: s = W'($urandom);
      endcase
      out_ready = 1'($urandom);
      send(sub, cout, s);
      take(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
